fb_addr_sequencer: RTL
======================

// Module: fb_addr_sequencer
// PURPOSE
//  Generates SDRAM frame-buffer read/write addresses as {bank,row,col} for the video path.
//  Arbitrates read/write requests into one outstanding SDRAM op, advances the owning channel by BURST pixels on op completion.
//  Wraps at frame end, optional ping-pong double buffering, and read-frame resync from the display timing.
//  Sits between the pixel producers/consumers and the SDRAM controller (Busy source).
// PARAMETERS
//  H_RES    640  active pixels per row; must be a multiple of BURST
//  V_RES    480  active rows per frame
//  COL_W    10   column field width, 2**COL_W >= H_RES
//  ROW_W    10   row field width, 2**ROW_W >= V_RES
//  BURST    1    pixels consumed per SDRAM op (column step)
//  ADDR_W   21   = 1+ROW_W+COL_W; address output width
// PORTS
//  Clk            in   1       system clock; all logic on rising edge
//  Reset          in   1       synchronous, active-high reset
//  Read           in   1       read request; sampled each cycle, sets read-pending
//  Write          in   1       write request; sampled each cycle, sets write-pending
//  Busy           in   1       SDRAM controller busy with the granted op
//  Mode           in   1       0 = single buffer (bank bit forced 0), 1 = ping-pong
//  Frame_Sync     in   1       1-cycle pulse: restart read channel at row 0/col 0
//  R_Address      out  ADDR_W  {R_Bank,R_Row,R_Col} current read address
//  W_Address      out  ADDR_W  {W_Bank,W_Row,W_Col} current write address
//  Rd_Grant       out  1       read op owns SDRAM (RD_ISSUE or RD_WAIT)
//  Wr_Grant       out  1       write op owns SDRAM (WR_ISSUE or WR_WAIT)
//  R_Frame_Done   out  1       1-cycle pulse when read channel wraps frame
//  W_Frame_Done   out  1       1-cycle pulse when write channel wraps frame
// BEHAVIOUR
//  Reset: all outputs 0 except R_Address bank bit = 1 when Mode=1 (R_Bank reg resets 1, W_Bank 0);
//   pending flags cleared, FSM -> IDLE. Reset dominates every other input in the same cycle.
//  Pending: Read=1 sets R_Pend, Write=1 sets W_Pend; cleared on entry to RD_ISSUE / WR_ISSUE.
//   Request arriving while its own op in flight is held pending (one extra op, not counted twice).
//  FSM: IDLE -> RD_ISSUE if R_Pend, else WR_ISSUE if W_Pend (read priority).
//   After a read completes with W_Pend set, write is granted next (no read back-to-back if write waits).
//   x_ISSUE: stays until Busy=1, then -> x_WAIT. x_WAIT: on Busy=0 -> advance channel, -> IDLE.
//   Address stable from grant through completion; advance visible the cycle after Busy falls.
//  Advance (per channel): Col += BURST; if Col+BURST == H_RES: Col=0, Row += 1;
//   if also Row == V_RES-1: Row=0, Frame_Done pulse, Bank toggles when Mode=1.
//   Col/Row never exceed H_RES-BURST / V_RES-1; arithmetic in COL_W+1 / ROW_W+1 bits, no overflow.
//  Mode=0: output bank bit 0, internal bank regs frozen. Mode change takes effect on next frame wrap
//   only for toggling; output masking is immediate.
//  Frame_Sync: read channel idle -> R_Row=R_Col=0 next cycle, bank unchanged, no Frame_Done.
//   Read op in flight -> sync latched, applied at completion instead of the advance.
//   Sync coincident with read wrap: sync wins, bank still toggles (Mode=1), Frame_Done pulses.
//  Write channel ignores Frame_Sync.
//  Busy high in IDLE is ignored; Busy never rising holds x_ISSUE (no timeout).
// TESTING (bench params H_RES=4 V_RES=3 BURST=2 COL_W=2 ROW_W=2)
//  Reset then Write pulse, Busy 1 for 3 cycles -> W_Address 0 -> {0,0,2} cycle after Busy falls.
//  6 write ops, Mode=1 -> W_Address walks col 0,2 rows 0..2, wraps to {1,0,0}, W_Frame_Done 1 cycle.
//  Read and Write same cycle in IDLE -> Rd_Grant first, Wr_Grant after read Busy falls; both advance once.
//  Frame_Sync during RD_WAIT at {1,1,2} -> after Busy falls R_Address={1,0,0}, no R_Frame_Done.
//  Mode=0, 6 read ops -> R_Address bank bit 0 throughout, R_Frame_Done at wrap.
//  Reset asserted in WR_WAIT -> next cycle FSM IDLE, all addresses reset values, no pending ops.

Source files
------------

// File: rtl/fb_addr_sequencer_if.sv
// Frame-buffer sequencer bundle: request/busy/mode/sync inputs to the sequencer, address/grant/frame pulses out.
// master = pixel producers/consumers plus SDRAM controller side; slave = the sequencer.
interface fb_addr_sequencer_if #(
    parameter int ADDR_W = 21
);
    logic              read;
    logic              write;
    logic              busy;
    logic              mode;
    logic              frame_sync;
    logic [ADDR_W-1:0] r_address;
    logic [ADDR_W-1:0] w_address;
    logic              rd_grant;
    logic              wr_grant;
    logic              r_frame_done;
    logic              w_frame_done;

    modport master (
        output read, write, busy, mode, frame_sync,
        input  r_address, w_address, rd_grant, wr_grant, r_frame_done, w_frame_done
    );

    modport slave (
        input  read, write, busy, mode, frame_sync,
        output r_address, w_address, rd_grant, wr_grant, r_frame_done, w_frame_done
    );
endinterface

// File: rtl/fb_addr_sequencer.sv
// Frame-buffer {bank,row,col} address sequencer: one SDRAM op in flight, read-priority arbitration.
// Grant two cycles after a request pulse; addresses advance the cycle after Busy falls; Busy stall holds the op.
module fb_addr_sequencer #(
    parameter int H_RES  = 640,
    parameter int V_RES  = 480,
    parameter int COL_W  = 10,
    parameter int ROW_W  = 10,
    parameter int BURST  = 1,
    parameter int ADDR_W = 1 + ROW_W + COL_W
) (
    input  logic               i_clk,
    input  logic               i_reset,
    fb_addr_sequencer_if.slave io_bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_ISSUE,
        S_RD_WAIT,
        S_WR_ISSUE,
        S_WR_WAIT
    } state_t;

    localparam logic [COL_W:0]   COL_STEP = (COL_W+1)'(BURST);
    localparam logic [COL_W:0]   COL_END  = (COL_W+1)'(H_RES);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(V_RES - 1);
    localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_rd_pend, r_wr_pend, r_last_rd, r_sync_pend;
    logic [COL_W-1:0]  r_rd_col, r_wr_col;
    logic [ROW_W-1:0]  r_rd_row, r_wr_row;
    logic              r_rd_bank, r_wr_bank;
    logic              r_rd_fdone, r_wr_fdone;

    logic [COL_W:0]    w_rd_col_sum, w_wr_col_sum;
    logic              w_rd_eol, w_rd_eof, w_wr_eol, w_wr_eof;
    logic              w_rd_active, w_rd_done, w_wr_done;
    logic              w_rd_start, w_wr_start, w_rd_sync;
    logic              w_rd_grant, w_wr_grant;
    logic [ADDR_W-1:0] w_rd_addr, w_wr_addr;

    assign w_rd_col_sum = {1'b0, r_rd_col} + COL_STEP;
    assign w_wr_col_sum = {1'b0, r_wr_col} + COL_STEP;
    assign w_rd_eol     = (w_rd_col_sum == COL_END);
    assign w_wr_eol     = (w_wr_col_sum == COL_END);
    assign w_rd_eof     = w_rd_eol && (r_rd_row == ROW_LAST);
    assign w_wr_eof     = w_wr_eol && (r_wr_row == ROW_LAST);

    assign w_rd_active  = (r_state == S_RD_ISSUE) || (r_state == S_RD_WAIT);
    assign w_rd_done    = (r_state == S_RD_WAIT) && !io_bus.busy;
    assign w_wr_done    = (r_state == S_WR_WAIT) && !io_bus.busy;
    assign w_rd_start   = (r_state == S_IDLE) && (w_state_nxt == S_RD_ISSUE);
    assign w_wr_start   = (r_state == S_IDLE) && (w_state_nxt == S_WR_ISSUE);
    // A sync seen on the completion cycle itself counts as latched.
    assign w_rd_sync    = r_sync_pend || io_bus.frame_sync;

    always_comb begin
        w_state_nxt = r_state;
        w_rd_grant  = 1'b0;
        w_wr_grant  = 1'b0;
        case (r_state)
            S_IDLE: begin
                // Read wins unless the op just finished was a read and a write is waiting.
                if (r_rd_pend && !(r_last_rd && r_wr_pend)) begin
                    w_state_nxt = S_RD_ISSUE;
                end else if (r_wr_pend) begin
                    w_state_nxt = S_WR_ISSUE;
                end
            end
            S_RD_ISSUE: begin
                w_rd_grant = 1'b1;
                if (io_bus.busy) w_state_nxt = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                w_rd_grant = 1'b1;
                if (!io_bus.busy) w_state_nxt = S_IDLE;
            end
            S_WR_ISSUE: begin
                w_wr_grant = 1'b1;
                if (io_bus.busy) w_state_nxt = S_WR_WAIT;
            end
            S_WR_WAIT: begin
                w_wr_grant = 1'b1;
                if (!io_bus.busy) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_rd_pend   <= 1'b0;
            r_wr_pend   <= 1'b0;
            r_last_rd   <= 1'b0;
            r_sync_pend <= 1'b0;
            r_rd_col    <= '0;
            r_rd_row    <= '0;
            r_rd_bank   <= 1'b1;
            r_wr_col    <= '0;
            r_wr_row    <= '0;
            r_wr_bank   <= 1'b0;
            r_rd_fdone  <= 1'b0;
            r_wr_fdone  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_rd_fdone <= 1'b0;
            r_wr_fdone <= 1'b0;
            r_rd_pend  <= w_rd_start ? 1'b0 : (r_rd_pend | io_bus.read);
            r_wr_pend  <= w_wr_start ? 1'b0 : (r_wr_pend | io_bus.write);

            if (w_rd_done) begin
                r_last_rd <= 1'b1;
            end else if (w_wr_done) begin
                r_last_rd <= 1'b0;
            end

            if (w_rd_done) begin
                r_sync_pend <= 1'b0;
            end else if (w_rd_active && io_bus.frame_sync) begin
                r_sync_pend <= 1'b1;
            end

            // Wrap bookkeeping still happens when a sync overrides the advance.
            if (w_rd_done) begin
                if (w_rd_eof) begin
                    r_rd_fdone <= 1'b1;
                    if (io_bus.mode) r_rd_bank <= ~r_rd_bank;
                end
                if (w_rd_sync || w_rd_eol) r_rd_col <= '0;
                else                       r_rd_col <= w_rd_col_sum[COL_W-1:0];
                if (w_rd_sync || w_rd_eof) r_rd_row <= '0;
                else if (w_rd_eol)         r_rd_row <= r_rd_row + ROW_ONE;
            end else if (!w_rd_active && io_bus.frame_sync) begin
                r_rd_col <= '0;
                r_rd_row <= '0;
            end

            if (w_wr_done) begin
                if (w_wr_eof) begin
                    r_wr_fdone <= 1'b1;
                    if (io_bus.mode) r_wr_bank <= ~r_wr_bank;
                end
                if (w_wr_eol) r_wr_col <= '0;
                else          r_wr_col <= w_wr_col_sum[COL_W-1:0];
                if (w_wr_eof)      r_wr_row <= '0;
                else if (w_wr_eol) r_wr_row <= r_wr_row + ROW_ONE;
            end
        end
    end

    assign w_rd_addr = {r_rd_bank & io_bus.mode, r_rd_row, r_rd_col};
    assign w_wr_addr = {r_wr_bank & io_bus.mode, r_wr_row, r_wr_col};

    assign io_bus.r_address    = w_rd_addr;
    assign io_bus.w_address    = w_wr_addr;
    assign io_bus.rd_grant     = w_rd_grant;
    assign io_bus.wr_grant     = w_wr_grant;
    assign io_bus.r_frame_done = r_rd_fdone;
    assign io_bus.w_frame_done = r_wr_fdone;
endmodule
